// File: rtl/ctrl_decode_pipe_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_decode_pipe_pkg
// Shared definitions for the pentaRV decode/control pipeline:
//   - RV32 base opcode values (unchanged from the first-generation decoder)
//   - immediate-format select codes, SrcA select codes, M-extension funct7
//   - MDU sequencer state encoding
//   - the control bundle carried across the D->E boundary
// ----------------------------------------------------------------------------
package ctrl_decode_pipe_pkg;

   // RV32 base opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_ALUREG = 7'b0110011;
   localparam logic [6:0] OP_ALUIMM = 7'b0010011;

   // Immediate-format select codes
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   // funct7 that marks an ALUreg instruction as M-extension
   localparam logic [6:0] MULDIV_F7 = 7'b0000001;

   // SrcA select codes
   localparam logic [1:0] SRCA_PC   = 2'b00;
   localparam logic [1:0] SRCA_ZERO = 2'b01;
   localparam logic [1:0] SRCA_RS1  = 2'b11;

   // MDU sequencer states
   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mduState_t;

   // Control bundle registered into E
   typedef struct packed {
      logic       regWrite;
      logic       memWrite;
      logic       pcBranch;
      logic       srcBSel;
      logic       memToReg;
      logic       mulDiv;
      logic [1:0] srcASel;
      logic [3:0] aluOp;
      logic [2:0] immSel;
      logic [2:0] strCtrl;
      logic [4:0] rd;
   } ctrlBundle_t;

   localparam ctrlBundle_t CTRL_BUBBLE = '0;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ctrl_decode_pipe_mdu_seq.sv
// ----------------------------------------------------------------------------
// mdu_seq
// Holds a multi-cycle MUL/DIV in E. On issue the down-counter is loaded with
// LAT-1; a non-zero load enters BUSY, which keeps the op in E until the
// counter reaches zero. The op then spends one more (non-stalling) cycle in E.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   start       MulDiv op is being issued into E this cycle
//   isDiv       issued op is DIV/REM (funct3[2])
//   stall       freeze FSM, counter and start pulse
//   flush       abort: back to IDLE, counter cleared
//   busy        op is being held in E (FSM in BUSY)
//   startPulse  registered, high in the first E cycle of an MDU op
// ----------------------------------------------------------------------------
module mdu_seq
   import ctrl_decode_pipe_pkg::*;
#(
   parameter int MUL_LAT = 1,
   parameter int DIV_LAT = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic isDiv,
   input  logic stall,
   input  logic flush,
   output logic busy,
   output logic startPulse
);

   localparam int CNT_W = $clog2(maxInt(MUL_LAT, DIV_LAT) + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mduState_t        stateR, stateNextS;
   logic [CNT_W-1:0] cntR, cntNextS, loadValS;
   logic             startPulseR, startPulseNextS;

   // Next-state, counter and start-pulse logic; flush beats stall
   always_comb begin
      stateNextS      = stateR;
      cntNextS        = cntR;
      startPulseNextS = startPulseR;
      loadValS        = isDiv ? DIV_LOAD : MUL_LOAD;
      if (flush) begin
         stateNextS      = MDU_IDLE;
         cntNextS        = '0;
         startPulseNextS = 1'b0;
      end else if (stall) begin
         stateNextS      = stateR;
         cntNextS        = cntR;
         startPulseNextS = startPulseR;
      end else begin
         case (stateR)
            MDU_IDLE: begin
               startPulseNextS = start;
               if (start) begin
                  cntNextS   = loadValS;
                  stateNextS = (loadValS != '0) ? MDU_BUSY : MDU_IDLE;
               end else begin
                  cntNextS   = '0;
                  stateNextS = MDU_IDLE;
               end
            end
            MDU_BUSY: begin
               startPulseNextS = 1'b0;
               // leaving BUSY as the counter hits zero leaves one final E cycle
               if (cntR <= CNT_ONE) begin
                  cntNextS   = '0;
                  stateNextS = MDU_IDLE;
               end else begin
                  cntNextS   = cntR - CNT_ONE;
                  stateNextS = MDU_BUSY;
               end
            end
            default: begin
               stateNextS      = MDU_IDLE;
               cntNextS        = '0;
               startPulseNextS = 1'b0;
            end
         endcase
      end
   end

   // State, counter and start-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateR      <= MDU_IDLE;
         cntR        <= '0;
         startPulseR <= 1'b0;
      end else begin
         stateR      <= stateNextS;
         cntR        <= cntNextS;
         startPulseR <= startPulseNextS;
      end
   end

   assign busy       = (stateR == MDU_BUSY);
   assign startPulse = startPulseR;

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ----------------------------------------------------------------------------
// ctrl_decode_pipe
// Decodes opcode/funct fields into the control bundle and registers it into
// the D->E boundary, with load-use bubbling, stall/flush handling and an MDU
// sequencer that holds multi-cycle MUL/DIV ops in E.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   validD, opcode, funct3,
//   funct7, rs1D, rs2D, rdD    D-stage instruction fields
//   stall_i                    downstream stall, freezes all state
//   flush_i                    kills E and D
//   stallD                     hold F/D this cycle (combinational)
//   validE ... rdE             registered E-stage control bundle
//   mdu_startE                 first-E-cycle pulse of an MDU op
// ----------------------------------------------------------------------------
module ctrl_decode_pipe
   import ctrl_decode_pipe_pkg::*;
#(
   parameter int MUL_LAT  = 1,
   parameter int DIV_LAT  = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       validD,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic [4:0] rs1D,
   input  logic [4:0] rs2D,
   input  logic [4:0] rdD,
   input  logic       stall_i,
   input  logic       flush_i,
   output logic       stallD,
   output logic       validE,
   output logic       RegWriteE,
   output logic       MemWriteE,
   output logic       PCBranchE,
   output logic       SrcBSelE,
   output logic       MemtoRegE,
   output logic       MulDivE,
   output logic [1:0] SrcASelE,
   output logic [3:0] ALUopE,
   output logic [2:0] immSelE,
   output logic [2:0] strCtrlE,
   output logic [4:0] rdE,
   output logic       mdu_startE
);

   ctrlBundle_t ctrlS;
   ctrlBundle_t eR;
   logic        validR;
   logic        useRs1S, useRs2S;
   logic        loadUseS;
   logic        mduBusyS;
   logic        advanceS;
   logic        mduIssueS;

   // Instruction decode into the control bundle plus register-usage flags
   always_comb begin
      ctrlS         = CTRL_BUBBLE;
      useRs1S       = 1'b1;
      useRs2S       = 1'b0;
      case (opcode)
         OP_LOAD: begin
            ctrlS.regWrite = 1'b1;
            ctrlS.memToReg = 1'b1;
            ctrlS.srcBSel  = 1'b1;
            ctrlS.srcASel  = SRCA_RS1;
            ctrlS.immSel   = IMM_I;
         end
         OP_STORE: begin
            ctrlS.memWrite = 1'b1;
            ctrlS.srcBSel  = 1'b1;
            ctrlS.srcASel  = SRCA_RS1;
            ctrlS.immSel   = IMM_S;
            useRs2S        = 1'b1;
         end
         OP_BRANCH: begin
            ctrlS.pcBranch = 1'b1;
            ctrlS.srcASel  = SRCA_RS1;
            ctrlS.aluOp    = {1'b0, funct3};
            ctrlS.immSel   = IMM_B;
            useRs2S        = 1'b1;
         end
         OP_JAL: begin
            ctrlS.regWrite = 1'b1;
            ctrlS.pcBranch = 1'b1;
            ctrlS.srcASel  = SRCA_PC;
            ctrlS.immSel   = IMM_J;
            useRs1S        = 1'b0;
         end
         OP_JALR: begin
            ctrlS.regWrite = 1'b1;
            ctrlS.pcBranch = 1'b1;
            ctrlS.srcASel  = SRCA_PC;
            ctrlS.immSel   = IMM_I;
         end
         OP_LUI: begin
            ctrlS.regWrite = 1'b1;
            ctrlS.srcBSel  = 1'b1;
            ctrlS.srcASel  = SRCA_ZERO;
            ctrlS.immSel   = IMM_U;
            useRs1S        = 1'b0;
         end
         OP_AUIPC: begin
            ctrlS.regWrite = 1'b1;
            ctrlS.srcBSel  = 1'b1;
            ctrlS.srcASel  = SRCA_PC;
            ctrlS.immSel   = IMM_U;
            useRs1S        = 1'b0;
         end
         OP_ALUREG: begin
            ctrlS.regWrite = 1'b1;
            ctrlS.srcASel  = SRCA_RS1;
            ctrlS.aluOp    = {funct7[5], funct3};
            ctrlS.mulDiv   = ENABLE_M && (funct7 == MULDIV_F7);
            useRs2S        = 1'b1;
         end
         OP_ALUIMM: begin
            ctrlS.regWrite = 1'b1;
            ctrlS.srcBSel  = 1'b1;
            ctrlS.srcASel  = SRCA_RS1;
            ctrlS.immSel   = IMM_I;
            // instr[30] only selects SRAI; for other funct3 it is immediate bits
            ctrlS.aluOp    = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
         end
         default: begin
            ctrlS   = CTRL_BUBBLE;
            useRs1S = 1'b1;
            useRs2S = 1'b0;
         end
      endcase
      ctrlS.strCtrl = funct3;
      ctrlS.rd      = rdD;
   end

   // Load-use hazard: a load in E writes a register the D instruction reads
   always_comb begin
      if (validR && eR.memToReg && (eR.rd != 5'd0) && validD) begin
         loadUseS = (useRs1S && (rs1D == eR.rd)) || (useRs2S && (rs2D == eR.rd));
      end else begin
         loadUseS = 1'b0;
      end
   end

   // Front-end hold request; a flush redirects fetch so D must not hold
   always_comb begin
      if (flush_i) begin
         stallD = 1'b0;
      end else begin
         stallD = stall_i || mduBusyS || loadUseS;
      end
   end

   assign advanceS  = !flush_i && !stall_i && !mduBusyS && !loadUseS;
   assign mduIssueS = advanceS && validD && ctrlS.mulDiv;

   mdu_seq #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_mdu_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (mduIssueS),
      .isDiv      (funct3[2]),
      .stall      (stall_i),
      .flush      (flush_i),
      .busy       (mduBusyS),
      .startPulse (mdu_startE)
   );

   // D->E pipeline register: flush > stall > MDU hold > bubble > advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validR <= 1'b0;
         eR     <= CTRL_BUBBLE;
      end else if (flush_i) begin
         validR <= 1'b0;
         eR     <= CTRL_BUBBLE;
      end else if (stall_i || mduBusyS) begin
         validR <= validR;
         eR     <= eR;
      end else if (loadUseS || !validD) begin
         validR <= 1'b0;
         eR     <= CTRL_BUBBLE;
      end else begin
         validR <= 1'b1;
         eR     <= ctrlS;
      end
   end

   assign validE    = validR;
   assign RegWriteE = eR.regWrite;
   assign MemWriteE = eR.memWrite;
   assign PCBranchE = eR.pcBranch;
   assign SrcBSelE  = eR.srcBSel;
   assign MemtoRegE = eR.memToReg;
   assign MulDivE   = eR.mulDiv;
   assign SrcASelE  = eR.srcASel;
   assign ALUopE    = eR.aluOp;
   assign immSelE   = eR.immSel;
   assign strCtrlE  = eR.strCtrl;
   assign rdE       = eR.rd;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// ----------------------------------------------------------------------------
// tb_ctrl_decode_pipe
// Directed bench: a table of single-instruction decode vectors followed by
// hand-written sequences for load-use, MDU hold, flush, stall and reset.
// ----------------------------------------------------------------------------
module tb_ctrl_decode_pipe;
   import ctrl_decode_pipe_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       validD;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rs1D, rs2D, rdD;
   logic       stall_i, flush_i;
   logic       stallD, validE;
   logic       RegWriteE, MemWriteE, PCBranchE, SrcBSelE, MemtoRegE, MulDivE;
   logic [1:0] SrcASelE;
   logic [3:0] ALUopE;
   logic [2:0] immSelE, strCtrlE;
   logic [4:0] rdE;
   logic       mdu_startE;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   ctrl_decode_pipe #(
      .MUL_LAT (1),
      .DIV_LAT (32),
      .ENABLE_M(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .validD(validD), .opcode(opcode),
      .funct3(funct3), .funct7(funct7), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
      .stall_i(stall_i), .flush_i(flush_i), .stallD(stallD), .validE(validE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCBranchE(PCBranchE),
      .SrcBSelE(SrcBSelE), .MemtoRegE(MemtoRegE), .MulDivE(MulDivE),
      .SrcASelE(SrcASelE), .ALUopE(ALUopE), .immSelE(immSelE),
      .strCtrlE(strCtrlE), .rdE(rdE), .mdu_startE(mdu_startE)
   );

   // {RegWrite,MemWrite,PCBranch,SrcBSel,MemtoReg,MulDiv,SrcASel,ALUop,immSel}
   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [14:0] ctrl;
      logic       start;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] ctrlVec();
      return {RegWriteE, MemWriteE, PCBranchE, SrcBSelE, MemtoRegE, MulDivE,
              SrcASelE, ALUopE, immSelE};
   endfunction

   function automatic logic [24:0] allOut();
      return {validE, ctrlVec(), strCtrlE, rdE, mdu_startE};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setD(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      validD = 1'b1; opcode = op; funct3 = f3; funct7 = f7;
      rs1D = r1; rs2D = r2; rdD = rd;
   endtask

   task automatic clearD();
      validD = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
      rs1D = 5'd0; rs2D = 5'd0; rdD = 5'd0;
   endtask

   // Issue a load, present a consumer, and check bubble behaviour
   task automatic loadUse(input string name, input logic [4:0] ldRd, input logic [6:0] op,
                          input logic [4:0] r1, input logic [4:0] r2, input logic expBubble);
      setD(OP_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, ldRd);
      tick();
      setD(op, 3'b000, 7'd0, r1, r2, 5'd6);
      #1;
      check({name, " stallD"}, 32'(stallD), 32'(expBubble));
      tick();
      if (expBubble) begin
         check({name, " bubble validE"}, 32'(validE), 32'd0);
         check({name, " stallD after bubble"}, 32'(stallD), 32'd0);
         tick();
      end
      check({name, " consumer in E"}, {26'd0, validE, rdE}, {26'd0, 1'b1, 5'd6});
      clearD();
      tick();
   endtask

   // Issue DIV x3 with ADDI x4 waiting in D; measure E occupancy and stalls
   task automatic runDiv(input string name, input int stallAt, input int stallLen,
                         input int expOcc, input int expStalls);
      int  occ;
      int  stalls;
      int  starts;
      bit  done;
      setD(OP_ALUREG, 3'b100, MULDIV_F7, 5'd1, 5'd2, 5'd3);
      tick();
      occ = 0; stalls = 0; starts = 0; done = 1'b0;
      if (validE && rdE == 5'd3 && MulDivE) occ++;
      if (mdu_startE) starts++;
      setD(OP_ALUIMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd4);
      for (int k = 0; k < 100 && !done; k++) begin
         stall_i = (k >= stallAt && k < stallAt + stallLen);
         #1;
         if (stallD) stalls++;
         tick();
         if (validE && rdE == 5'd4) begin
            done = 1'b1;
         end else begin
            if (validE && rdE == 5'd3 && MulDivE) occ++;
            if (mdu_startE) starts++;
         end
      end
      stall_i = 1'b0;
      check({name, " completed"}, 32'(done), 32'd1);
      check({name, " E occupancy"}, 32'(occ), 32'(expOcc));
      check({name, " stallD cycles"}, 32'(stalls), 32'(expStalls));
      check({name, " start pulses"}, 32'(starts), 32'd1);
      check({name, " no start on next op"}, 32'(mdu_startE), 32'd0);
      clearD();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{"ADDI",   OP_ALUIMM, 3'b000, 7'b0000000, 5'd0, 5'd5, 5'd1, 15'b100100_11_0000_000, 1'b0};
      vecs[1]  = '{"JAL",    OP_JAL,    3'b000, 7'b0000000, 5'd0, 5'd0, 5'd2, 15'b101000_00_0000_100, 1'b0};
      vecs[2]  = '{"SRAI",   OP_ALUIMM, 3'b101, 7'b0100000, 5'd1, 5'd3, 5'd9, 15'b100100_11_1101_000, 1'b0};
      vecs[3]  = '{"ADDI30", OP_ALUIMM, 3'b000, 7'b0100000, 5'd1, 5'd3, 5'd9, 15'b100100_11_0000_000, 1'b0};
      vecs[4]  = '{"SUB",    OP_ALUREG, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd10, 15'b100000_11_1000_000, 1'b0};
      vecs[5]  = '{"LW",     OP_LOAD,   3'b010, 7'b0000000, 5'd1, 5'd0, 5'd11, 15'b100110_11_0000_000, 1'b0};
      vecs[6]  = '{"SW",     OP_STORE,  3'b010, 7'b0000000, 5'd1, 5'd2, 5'd12, 15'b010100_11_0000_001, 1'b0};
      vecs[7]  = '{"BNE",    OP_BRANCH, 3'b001, 7'b0000000, 5'd1, 5'd2, 5'd13, 15'b001000_11_0001_010, 1'b0};
      vecs[8]  = '{"LUI",    OP_LUI,    3'b000, 7'b0000000, 5'd0, 5'd0, 5'd14, 15'b100100_01_0000_011, 1'b0};
      vecs[9]  = '{"AUIPC",  OP_AUIPC,  3'b000, 7'b0000000, 5'd0, 5'd0, 5'd15, 15'b100100_00_0000_011, 1'b0};
      vecs[10] = '{"JALR",   OP_JALR,   3'b000, 7'b0000000, 5'd1, 5'd0, 5'd16, 15'b101000_00_0000_000, 1'b0};
      vecs[11] = '{"MUL",    OP_ALUREG, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd17, 15'b100001_11_0000_000, 1'b1};
      vecs[12] = '{"SLTIU",  OP_ALUIMM, 3'b011, 7'b0100000, 5'd1, 5'd0, 5'd18, 15'b100100_11_0011_000, 1'b0};
      vecs[13] = '{"SRLI",   OP_ALUIMM, 3'b101, 7'b0000000, 5'd1, 5'd0, 5'd19, 15'b100100_11_0101_000, 1'b0};

      // reset state
      rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      clearD();
      #12;
      check("reset outputs", 32'(allOut()), 32'd0);
      check("reset stallD", 32'(stallD), 32'd0);
      stall_i = 1'b1;
      #1;
      check("reset stallD follows stall_i", 32'(stallD), 32'd1);
      stall_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // decode table
      for (int i = 0; i < 14; i++) begin
         setD(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
         #1;
         check({vecs[i].name, " stallD"}, 32'(stallD), 32'd0);
         tick();
         check({vecs[i].name, " ctrl"}, 32'(ctrlVec()), 32'(vecs[i].ctrl));
         check({vecs[i].name, " valid/rd/f3"}, {23'd0, validE, rdE, strCtrlE},
               {23'd0, 1'b1, vecs[i].rd, vecs[i].f3});
         check({vecs[i].name, " mdu_start"}, 32'(mdu_startE), 32'(vecs[i].start));
         clearD();
         tick();
         check({vecs[i].name, " idle bubble"}, 32'(allOut()), 32'd0);
      end

      // load-use cases
      loadUse("lu rs1",      5'd5, OP_ALUREG, 5'd5, 5'd7, 1'b1);
      loadUse("lu rs2 store", 5'd5, OP_STORE, 5'd1, 5'd5, 1'b1);
      loadUse("lu x0",       5'd0, OP_ALUREG, 5'd0, 5'd0, 1'b0);
      loadUse("lu lui",      5'd5, OP_LUI,    5'd5, 5'd5, 1'b0);

      // MUL with MUL_LAT=1: no stall, next op follows immediately
      setD(OP_ALUREG, 3'b000, MULDIV_F7, 5'd1, 5'd2, 5'd3);
      tick();
      check("mul start", {30'd0, mdu_startE, MulDivE}, {30'd0, 1'b1, 1'b1});
      setD(OP_ALUIMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd4);
      #1;
      check("mul no stall", 32'(stallD), 32'd0);
      tick();
      check("mul next op", {25'd0, validE, rdE, mdu_startE}, {25'd0, 1'b1, 5'd4, 1'b0});
      clearD();
      tick();

      // DIV timing with and without a mid-op stall_i
      runDiv("div",       1000, 0, 32, 31);
      runDiv("div stall", 5,    3, 35, 34);

      // flush in the 10th BUSY cycle
      setD(OP_ALUREG, 3'b101, MULDIV_F7, 5'd1, 5'd2, 5'd3);
      tick();
      setD(OP_ALUIMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd4);
      repeat (9) tick();
      check("flush pre busy stallD", 32'(stallD), 32'd1);
      flush_i = 1'b1;
      #1;
      check("flush stallD", 32'(stallD), 32'd0);
      tick();
      flush_i = 1'b0;
      check("flush bubble", 32'(allOut()), 32'd0);
      #1;
      check("flush fsm idle", 32'(stallD), 32'd0);
      tick();
      check("flush next op", {25'd0, validE, rdE, mdu_startE}, {25'd0, 1'b1, 5'd4, 1'b0});
      clearD();
      tick();

      // stall_i on ordinary instructions holds E
      setD(OP_ALUIMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd7);
      tick();
      setD(OP_ALUIMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd9);
      stall_i = 1'b1;
      #1;
      check("stall stallD", 32'(stallD), 32'd1);
      tick();
      check("stall holds E", {26'd0, validE, rdE}, {26'd0, 1'b1, 5'd7});
      stall_i = 1'b0;
      tick();
      check("stall release", {26'd0, validE, rdE}, {26'd0, 1'b1, 5'd9});
      clearD();
      tick();

      // asynchronous reset mid-DIV
      setD(OP_ALUREG, 3'b100, MULDIV_F7, 5'd1, 5'd2, 5'd3);
      tick();
      clearD();
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset outputs", 32'(allOut()), 32'd0);
      check("async reset stallD", 32'(stallD), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      setD(OP_ALUIMM, 3'b000, 7'd0, 5'd0, 5'd0, 5'd4);
      #1;
      check("post reset stallD", 32'(stallD), 32'd0);
      tick();
      check("post reset op", {25'd0, validE, rdE, mdu_startE}, {25'd0, 1'b1, 5'd4, 1'b0});
      clearD();
      tick();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Second-generation decode control for the pentaRV pipeline: decodes opcode/funct fields into the control bundle and registers it into the D→E pipeline boundary. Adds what the first-generation combinational decoder lacked: load-use hazard bubbling, flush/stall handling, RegWrite for JAL/JALR/LUI/AUIPC, defined immediate-select codes, and an M-extension sequencer. The sequencer holds a multi-cycle MUL/DIV in E for a parametrised latency.

## Interface
Parameters:
- MUL_LAT, 1, cycles a MUL* op occupies E (≥1)
- DIV_LAT, 32, cycles a DIV*/REM* op occupies E (≥1)
- ENABLE_M, 1, 0 decodes funct7=0000001 ALUreg as ordinary ALU op (MulDivE never set)

Ports. One clock; reset is asynchronous and active-low, clock port `clk`, reset port `rst_n`.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- validD  in  1  D-stage instruction valid
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- rs1D, rs2D, rdD  in  5 each  register indices
- stall_i  in  1  downstream memory stall; freezes all state
- flush_i  in  1  taken branch/jump resolved in E; kills E and D
- stallD  out  1  hold F/D registers this cycle
- validE  out  1  E-stage instruction valid
- RegWriteE, MemWriteE, PCBranchE, SrcBSelE, MemtoRegE, MulDivE  out  1 each
- SrcASelE  out  2  00 PC (JAL/JALR/AUIPC), 01 zero (LUI), 11 rs1
- ALUopE  out  4  ALU operation
- immSelE  out  3  immediate format
- strCtrlE  out  3  funct3 passthrough (load/store size, MDU op)
- rdE  out  5  destination index
- mdu_startE  out  1  one-cycle pulse when an MDU op enters E

## Operation
- Decode: RegWrite for Load, ALUreg, ALUimm, JAL, JALR, LUI, AUIPC. MemWrite for Store. MemtoReg for Load. PCBranch for Branch, JAL, JALR. SrcBSel for Load, Store, ALUimm, LUI, AUIPC.
- ALUop: 0000 for Load/Store/JAL/JALR/AUIPC/LUI. {funct7[5],funct3} for ALUreg. For ALUimm, funct7[5] is used only when funct3=101 (SRAI); otherwise {0,funct3}. Branch: {0,funct3}.
- immSel: 000 I (Load/ALUimm/JALR), 001 S, 010 B, 011 U, 100 J.
- MulDiv = ENABLE_M & ALUreg & funct7=0000001.
- Register usage: rs1 used by all except LUI/AUIPC/JAL. rs2 used by ALUreg/Store/Branch.
- Load-use hazard when validE & MemtoRegE & rdE≠0 & validD & rdE matches a used rs. Response: E loads a bubble, stallD=1 for that cycle.
- Bubble: validE=0 and every control output 0, including rdE.
- MDU FSM (IDLE, BUSY):
  - On issue of an MulDiv op into E, cnt is loaded with LAT-1, where LAT = DIV_LAT if funct3[2] else MUL_LAT.
  - If the loaded value ≠0, go to BUSY.
  - In BUSY, E holds and stallD=1. cnt decrements each unstalled cycle. At cnt=0 return to IDLE; the op leaves E on the next edge.
- Priority per edge: reset > flush_i > stall_i > MDU hold > load-use bubble > normal advance.
- flush_i: E becomes a bubble; FSM→IDLE with cnt=0; stallD=0.
- stall_i: E, FSM and cnt all hold; stallD=1.
- validD=0 on advance: E becomes a bubble.

## Timing
- Reset: all E outputs 0, validE=0, mdu_startE=0, FSM IDLE, cnt=0. stallD=0 unless stall_i.
- Decode latency: an instruction present in D at edge t appears on the E outputs after edge t.
- stallD is combinational from validD, rs, E regs, FSM and stall_i. No combinational path from flush_i to the E outputs.
- MDU op with LAT=L: stays in E exactly L cycles absent stall_i/flush; stallD is high L-1 cycles. L=1 gives zero stall.
- mdu_startE: high only during the first E cycle of the op; not reasserted while held.
- Flush during BUSY aborts the op; no mdu_startE follows.
- Reset asserted mid-BUSY: immediate return to IDLE and bubble.
- cnt width: $clog2(max(MUL_LAT,DIV_LAT)+1).

## Structure
- Add to defines.v:
  - immSel codes IMM_I/S/B/U/J
  - MULDIV funct7 constant
  - SrcASel codes
  - MDU FSM state encodings
- Opcode defines are reused unchanged.
- Sub-module `mdu_seq`: FSM plus down-counter. Inputs start, is_div, stall, flush. Outputs busy, start pulse.
- Top contains the decode logic, hazard compare and E register.

## Test plan
- ADDI x1 then JAL x2 → E shows RegWriteE=1 for both. JAL: SrcASelE=00, PCBranchE=1, immSelE=100.
- LW x5 then ADD x6,x5,x7 → one bubble (validE=0), stallD=1 for one cycle, ADD issues next cycle. LW x0 followed by a use of x0 → no bubble.
- DIV with DIV_LAT=32 → mdu_startE pulses once, stallD high 31 cycles, next instruction enters E on cycle 33. MUL with MUL_LAT=1 → zero stall.
- flush_i in the 10th BUSY cycle of DIV → validE=0 and FSM IDLE next cycle, stallD=0.
- stall_i for 3 cycles during BUSY → cnt frozen; total E occupancy DIV_LAT+3.
- SRAI (funct7=0100000, funct3=101) → ALUopE=1101. ADDI with instr[30]=1 → ALUopE=0000. rst_n low mid-op → all outputs 0 asynchronously.
